exu_inst_queue: RTL and testbench
=================================

EXU_INST_QUEUE -- requirements
Module: exu_inst_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of queue entries; legal values are powers of two from 2 to 16.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port flush, input, 1 bit: discards all queued instructions.
REQ-005 Port in_vld, input, 1 bit: the fetch side offers an instruction.
REQ-006 Port in_rdy, output, 1 bit: the queue accepts the offered instruction.
REQ-007 Port in_inst, input, 32 bits: the fetched instruction word.
REQ-008 Port in_pc, input, 32 bits: the PC of the fetched instruction.
REQ-009 Port out_vld, output, 1 bit: the head instruction is valid for the execute handlers.
REQ-010 Port out_rdy, input, 1 bit: the execute stage consumes the head instruction this cycle.
REQ-011 Port out_inst, output, 32 bits: the head instruction word.
REQ-012 Port out_pc, output, 32 bits: the head PC.
REQ-013 Port out_alu_sel, output, 1 bit: select for the ALU handler.
REQ-014 Port count, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-015 The block SHALL be a circular FIFO: a push occurs when in_vld and in_rdy are both high; a pop occurs when out_vld and out_rdy are both high.
REQ-016 in_rdy SHALL equal (count != DEPTH) and not flush; it SHALL NOT depend on out_rdy, so a full queue with a pop pending still stalls the push that cycle.
REQ-017 out_vld SHALL equal (count != 0) and not flush.
REQ-018 out_inst and out_pc SHALL come from the head entry; when the queue is empty they SHALL be 0.
REQ-019 out_alu_sel SHALL be high iff out_vld is high and out_inst[6:0] is 7'b0010011 (ALUI) or 7'b0110011 (ALU).
REQ-020 Write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-021 Simultaneous push and pop when not full and not empty SHALL leave count unchanged and advance both pointers.
REQ-022 Latency from push to out_vld SHALL be 1 cycle; an instruction pushed at edge N is visible after edge N.
REQ-023 When flush is high, pointers and count SHALL clear at the next edge; any push or pop in that cycle SHALL be discarded.
REQ-024 Ordering SHALL be strict FIFO; no entry is overwritten before it is popped.

Reset
REQ-025 When rst is high at a rising edge, pointers and count SHALL go to 0, which drives out_vld=0, out_alu_sel=0, out_inst=0, out_pc=0 and in_rdy=1 (in_rdy=0 while flush is high).
REQ-026 Entry storage SHALL NOT require reset.
REQ-027 rst SHALL take priority over flush and over all handshakes; an assertion mid-stream drops all entries.

Configuration
REQ-028 Macro INST_QUEUE_BYPASS_EN SHALL control same-cycle bypass.
REQ-029 With INST_QUEUE_BYPASS_EN defined:
- When the queue is empty, in_vld is high and flush is low, out_vld SHALL be 1 and out_inst, out_pc and out_alu_sel SHALL reflect in_inst and in_pc combinationally.
- If out_rdy is also high, the instruction SHALL be consumed without being written and count stays 0.
- Otherwise it SHALL be written normally.
REQ-030 Without INST_QUEUE_BYPASS_EN, no combinational path SHALL exist from in_* to out_*, and latency SHALL be exactly 1 cycle.

Verification
REQ-031 Reset then idle: expect out_vld=0, in_rdy=1, count=0.
REQ-032 Fill test, DEPTH=4, out_rdy=0: push 0x00500093 (addi), 0x002081B3 (add), 0x00000063 (beq), 0x00112023 (sw).
- Expect count=4 and in_rdy=0.
- Head out_alu_sel=1 for the first two instructions and 0 for the last two.
REQ-033 Full queue, in_vld=1 and out_rdy=1 in the same cycle: expect a pop only, count 4->3, and the push accepted the following cycle.
REQ-034 Streaming, out_rdy=1 with 10 back-to-back pushes, PCs 0x0..0x24:
- Pops occur in order.
- Pointer wrap is exercised.
- count never exceeds 1 without the macro and stays 0 with it.
REQ-035 Flush with 3 entries while pushing: expect count=0 next cycle, the pushed word not output, and out_vld=0.
REQ-036 Reset asserted with 2 entries queued: expect out_vld=0 and count=0 after the edge, and subsequent pushes dequeued from fresh pointers.

Source files
------------

// File: rtl/exu_inst_queue.sv
// Instruction queue between fetch and the execute handlers: circular FIFO with flush.
// Optional same-cycle bypass of an empty queue is enabled by defining INST_QUEUE_BYPASS_EN.
module exu_inst_queue #(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_vld,
   output logic                   in_rdy,
   input  logic [31:0]            in_inst,
   input  logic [31:0]            in_pc,
   output logic                   out_vld,
   input  logic                   out_rdy,
   output logic [31:0]            out_inst,
   output logic [31:0]            out_pc,
   output logic                   out_alu_sel,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
   localparam logic [6:0]  OP_ALUI = 7'b0010011;
   localparam logic [6:0]  OP_ALU  = 7'b0110011;

   logic [31:0]   inst_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [AW:0]   count_reg;

   logic          empty;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic          rd_en;
   logic [31:0]   head_inst;
   logic [31:0]   head_pc;

   assign empty     = (count_reg == '0);
   assign in_rdy    = (count_reg != FULL) && !flush;
   assign push      = in_vld && in_rdy;
   assign pop       = out_vld && out_rdy;
   assign head_inst = empty ? 32'h0 : inst_mem[rd_ptr_reg];
   assign head_pc   = empty ? 32'h0 : pc_mem[rd_ptr_reg];

`ifdef INST_QUEUE_BYPASS_EN
   logic bypass;

   // An empty queue forwards the offered instruction straight to the head.
   assign bypass   = empty && in_vld && !flush;
   assign out_vld  = bypass || (!empty && !flush);
   assign out_inst = bypass ? in_inst : head_inst;
   assign out_pc   = bypass ? in_pc : head_pc;
   // A bypassed instruction consumed in the same cycle never occupies an entry.
   assign wr_en    = push && !(bypass && out_rdy);
`else
   assign out_vld  = !empty && !flush;
   assign out_inst = head_inst;
   assign out_pc   = head_pc;
   assign wr_en    = push;
`endif

   assign rd_en       = pop && !empty;
   assign out_alu_sel = out_vld && ((out_inst[6:0] == OP_ALUI) || (out_inst[6:0] == OP_ALU));
   assign count       = count_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         inst_mem[wr_ptr_reg] <= in_inst;
         pc_mem[wr_ptr_reg]   <= in_pc;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end
endmodule

// File: tb/tb_exu_inst_queue.sv
// Directed bench for exu_inst_queue (DEPTH=4): vector table plus a streaming sequence.
module tb_exu_inst_queue;
   logic        clk = 1'b0;
   logic        rst, flush, in_vld, in_rdy, out_vld, out_rdy, out_alu_sel;
   logic [31:0] in_inst, in_pc, out_inst, out_pc;
   logic [2:0]  count;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        vld;
      logic        rdy;
      logic [31:0] inst;
      logic [31:0] pc;
      logic        e_vld;
      logic        e_in_rdy;
      logic [2:0]  e_cnt;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic        e_alu;
      logic        chk_data;
   } vec_t;

   vec_t vecs[$];

   exu_inst_queue #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_inst(in_inst), .in_pc(in_pc),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_inst(out_inst), .out_pc(out_pc),
      .out_alu_sel(out_alu_sel), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic v, input logic rd,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic e_vld, input logic e_in_rdy, input logic [2:0] e_cnt,
                      input logic [31:0] e_inst, input logic [31:0] e_pc,
                      input logic e_alu, input logic chk_data);
      vec_t t;
      t.rst = r; t.flush = f; t.vld = v; t.rdy = rd; t.inst = inst; t.pc = pc;
      t.e_vld = e_vld; t.e_in_rdy = e_in_rdy; t.e_cnt = e_cnt;
      t.e_inst = e_inst; t.e_pc = e_pc; t.e_alu = e_alu; t.chk_data = chk_data;
      vecs.push_back(t);
   endtask

   function automatic logic is_alu(input logic [31:0] inst);
      logic [6:0] op;
      op = inst[6:0];
      return (op == 7'h13) || (op == 7'h33);
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
      in_inst = '0; in_pc = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      //   rst f  vld rdy inst          pc          vld in_rdy cnt exp_inst      exp_pc   alu chk
      add(0, 0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,        32'h0,   0, 1); // 0 idle after reset
      add(0, 0, 1, 0, 32'h00500093, 32'h100, 0, 1, 0, 32'h0,        32'h0,   0, 1); // 1 addi
      add(0, 0, 1, 0, 32'h002081B3, 32'h104, 1, 1, 1, 32'h00500093, 32'h100, 1, 1); // 2 add
      add(0, 0, 1, 0, 32'h00000063, 32'h108, 1, 1, 2, 32'h00500093, 32'h100, 1, 1); // 3 beq
      add(0, 0, 1, 0, 32'h00112023, 32'h10C, 1, 1, 3, 32'h00500093, 32'h100, 1, 1); // 4 sw
      add(0, 0, 1, 1, 32'hAAAA0013, 32'h110, 1, 0, 4, 32'h00500093, 32'h100, 1, 1); // 5 full: pop only
      add(0, 0, 1, 0, 32'hAAAA0013, 32'h110, 1, 1, 3, 32'h002081B3, 32'h104, 1, 1); // 6 push accepted
      add(0, 0, 0, 1, 32'h0,        32'h0,   1, 0, 4, 32'h002081B3, 32'h104, 1, 1); // 7
      add(0, 0, 0, 1, 32'h0,        32'h0,   1, 1, 3, 32'h00000063, 32'h108, 0, 1); // 8
      add(0, 0, 0, 1, 32'h0,        32'h0,   1, 1, 2, 32'h00112023, 32'h10C, 0, 1); // 9
      add(0, 0, 0, 0, 32'h0,        32'h0,   1, 1, 1, 32'hAAAA0013, 32'h110, 1, 1); // 10 wrapped entry
      add(0, 0, 0, 1, 32'h0,        32'h0,   1, 1, 1, 32'hAAAA0013, 32'h110, 1, 1); // 11
      add(0, 0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,        32'h0,   0, 1); // 12 empty
      add(0, 0, 1, 0, 32'h00000033, 32'h200, 0, 1, 0, 32'h0,        32'h0,   0, 1); // 13
      add(0, 0, 1, 0, 32'h00100013, 32'h204, 1, 1, 1, 32'h00000033, 32'h200, 1, 1); // 14
      add(0, 0, 1, 0, 32'h00000073, 32'h208, 1, 1, 2, 32'h00000033, 32'h200, 1, 1); // 15
      add(0, 1, 1, 1, 32'h12345013, 32'h20C, 0, 0, 3, 32'h0,        32'h0,   0, 0); // 16 flush
      add(0, 0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,        32'h0,   0, 1); // 17
      add(0, 0, 1, 0, 32'h11111013, 32'h300, 0, 1, 0, 32'h0,        32'h0,   0, 1); // 18
      add(0, 0, 1, 0, 32'h22222013, 32'h304, 1, 1, 1, 32'h11111013, 32'h300, 1, 1); // 19
      add(1, 0, 1, 1, 32'h33333013, 32'h308, 1, 1, 2, 32'h11111013, 32'h300, 1, 1); // 20 reset mid-stream
      add(0, 0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,        32'h0,   0, 1); // 21
      add(0, 0, 1, 0, 32'h44444033, 32'h400, 0, 1, 0, 32'h0,        32'h0,   0, 1); // 22
      add(0, 0, 0, 1, 32'h0,        32'h0,   1, 1, 1, 32'h44444033, 32'h400, 1, 1); // 23
      add(0, 0, 0, 0, 32'h0,        32'h0,   0, 1, 0, 32'h0,        32'h0,   0, 1); // 24

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
`ifdef INST_QUEUE_BYPASS_EN
         if (v.e_cnt == 3'd0 && v.vld && !v.flush && !v.rst) begin
            v.e_vld = 1'b1; v.e_inst = v.inst; v.e_pc = v.pc; v.e_alu = is_alu(v.inst);
         end
`endif
         rst = v.rst; flush = v.flush; in_vld = v.vld; out_rdy = v.rdy;
         in_inst = v.inst; in_pc = v.pc;
         #4;
         $display("vec %0d: vld=%b in_rdy=%b cnt=%0d inst=%h pc=%h alu=%b",
                  i, out_vld, in_rdy, count, out_inst, out_pc, out_alu_sel);
         chk($sformatf("v%0d out_vld", i), 32'(out_vld), 32'(v.e_vld));
         chk($sformatf("v%0d in_rdy", i), 32'(in_rdy), 32'(v.e_in_rdy));
         chk($sformatf("v%0d count", i), 32'(count), 32'(v.e_cnt));
         chk($sformatf("v%0d alu_sel", i), 32'(out_alu_sel), 32'(v.e_alu));
         if (v.chk_data) begin
            chk($sformatf("v%0d out_inst", i), out_inst, v.e_inst);
            chk($sformatf("v%0d out_pc", i), out_pc, v.e_pc);
         end
         @(posedge clk);
         #1;
      end
      rst = 1'b0; flush = 1'b0;

      // Streaming: ten back-to-back pushes with the consumer always ready.
      for (int k = 0; k <= 10; k++) begin
         logic       e_vld;
         logic [2:0] e_cnt;
         int         src;
         in_vld  = (k < 10);
         out_rdy = 1'b1;
         in_pc   = 32'(k * 4);
         in_inst = 32'h00000013 | (32'(k) << 20);
`ifdef INST_QUEUE_BYPASS_EN
         e_vld = (k < 10); e_cnt = 3'd0; src = k;
`else
         e_vld = (k > 0); e_cnt = (k > 0) ? 3'd1 : 3'd0; src = k - 1;
`endif
         #4;
         $display("stream %0d: vld=%b cnt=%0d pc=%h inst=%h", k, out_vld, count, out_pc, out_inst);
         chk($sformatf("s%0d out_vld", k), 32'(out_vld), 32'(e_vld));
         chk($sformatf("s%0d count", k), 32'(count), 32'(e_cnt));
         if (e_vld) begin
            chk($sformatf("s%0d out_pc", k), out_pc, 32'(src * 4));
            chk($sformatf("s%0d out_inst", k), out_inst, 32'h00000013 | (32'(src) << 20));
         end
         @(posedge clk);
         #1;
      end
      in_vld = 1'b0; out_rdy = 1'b0;
      #4;
      chk("drain out_vld", 32'(out_vld), 32'h0);
      chk("drain count", 32'(count), 32'h0);
      @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
